// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX controller and baud generator.
package uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } uart_tx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Start + data + stop, plus one parity bit when enabled.
    function automatic int unsigned frame_bits(input int unsigned data_bits, input bit parity_en);
        return data_bits + (parity_en ? 32'd3 : 32'd2);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter with synchronous clear and enable; ticks for one cycle at terminal count.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == TERM) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready byte intake, frame register load/shift paced by uart_baud_gen.
// Define UART_TX_PARITY_EN to insert a parity bit between the data MSB and the stop bit.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PARITY_EN);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    uart_tx_state_t          state_q, state_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   load_frame;
    logic                    baud_clear;
    logic                    baud_en;
    logic                    baud_tick;

    // Without parity, index DATA_BITS+1 is already the stop bit, so the parity write is dead.
    always_comb begin
        load_frame                = '1;
        load_frame[0]             = 1'b0;
        load_frame[DATA_BITS:1]   = tx_data;
        if (PARITY_EN) begin
            load_frame[DATA_BITS+1] = ^tx_data ^ PARITY_ODD;
        end
    end

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .en   (baud_en),
        .tick (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        baud_clear = 1'b0;
        baud_en    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    frame_d    = load_frame;
                    bit_cnt_d  = '0;
                    baud_clear = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                baud_en = 1'b1;
                if (baud_tick) begin
                    frame_d   = {1'b1, frame_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            frame_q   <= '1;
            bit_cnt_q <= '1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign tx   = frame_q[0];
    assign busy = !tx_ready;

    // Fill-with-ones shifting must leave the line high whenever the FSM is idle.
    a_idle_line_high: assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE) |-> tx);

    a_done_returns_idle: assert property (@(posedge clk) disable iff (reset)
        tx_done |=> (state_q == IDLE));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl; honours UART_TX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int CPB_A = 4;
    localparam int DB_A  = 8;
    localparam int CPB_B = 2;
    localparam int DB_B  = 5;

`ifdef UART_TX_PARITY_EN
    localparam int FB_A = 11;
    localparam int FB_B = 8;
    localparam logic [15:0] FR_A5 = 16'b10101001010;
    localparam logic [15:0] FR_07 = 16'b11000001110;
    localparam logic [15:0] FR_00 = 16'b10000000000;
    localparam logic [15:0] FR_FF = 16'b10111111110;
    localparam logic [15:0] FR_3C = 16'b10001111000;
    localparam logic [15:0] FR_15 = 16'b11101010;
`else
    localparam int FB_A = 10;
    localparam int FB_B = 7;
    localparam logic [15:0] FR_A5 = 16'b1101001010;
    localparam logic [15:0] FR_00 = 16'b1000000000;
    localparam logic [15:0] FR_FF = 16'b1111111110;
    localparam logic [15:0] FR_3C = 16'b1001111000;
    localparam logic [15:0] FR_15 = 16'b1101010;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [DB_A-1:0] tx_data_a;
    logic            tx_valid_a;
    logic            tx_ready_a, tx_a, busy_a, tx_done_a;
    logic [DB_B-1:0] tx_data_b;
    logic            tx_valid_b;
    logic            tx_ready_b, tx_b, busy_b, tx_done_b;

    int vectors     = 0;
    int miscompares = 0;
    int acc_a       = 0;
    int acc_b       = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB_A),
        .DATA_BITS   (DB_A),
        .PARITY_ODD  (1'b0)
    ) dut_a (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data_a),
        .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a),
        .tx      (tx_a),
        .busy    (busy_a),
        .tx_done (tx_done_a)
    );

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB_B),
        .DATA_BITS   (DB_B),
        .PARITY_ODD  (1'b0)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data_b),
        .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .tx_done (tx_done_b)
    );

    always @(posedge clk) begin
        if (!reset && tx_valid_a && tx_ready_a) acc_a++;
        if (!reset && tx_valid_b && tx_ready_b) acc_b++;
    end

    // Caller raises tx_valid at a negedge; returns at the negedge of cycle N+1 after accept.
    task automatic check_frame(input bit sel, input logic [15:0] frame, input int nbits,
                               input int cpb, input bit hold_valid, input string name);
        int n;
        logic exp_tx, exp_done, exp_ready;
        logic o_tx, o_done, o_ready, o_busy;
        n = nbits * cpb;
        @(posedge clk);
        @(negedge clk);
        if (sel) begin
            tx_data_b = ~tx_data_b;
            if (!hold_valid) tx_valid_b = 1'b0;
        end else begin
            tx_data_a = ~tx_data_a;
            if (!hold_valid) tx_valid_a = 1'b0;
        end
        for (int k = 1; k <= n + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= n) begin
                exp_tx    = frame[(k-1)/cpb];
                exp_ready = 1'b0;
            end else begin
                exp_tx    = 1'b1;
                exp_ready = 1'b1;
            end
            exp_done = (k == n);
            o_tx    = sel ? tx_b       : tx_a;
            o_done  = sel ? tx_done_b  : tx_done_a;
            o_ready = sel ? tx_ready_b : tx_ready_a;
            o_busy  = sel ? busy_b     : busy_a;
            vectors++;
            if (o_tx !== exp_tx) begin
                miscompares++;
                $display("FAIL %s tx cycle %0d: got %b expected %b", name, k, o_tx, exp_tx);
            end
            vectors++;
            if (o_done !== exp_done) begin
                miscompares++;
                $display("FAIL %s tx_done cycle %0d: got %b expected %b", name, k, o_done, exp_done);
            end
            vectors++;
            if (o_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL %s tx_ready cycle %0d: got %b expected %b", name, k, o_ready, exp_ready);
            end
            vectors++;
            if (o_busy !== !exp_ready) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, o_busy, !exp_ready);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({tx_a, tx_ready_a, busy_a, tx_done_a} !== 4'b1100) begin
            miscompares++;
            $display("FAIL %s dut_a {tx,ready,busy,done}: got %b expected 1100", name,
                     {tx_a, tx_ready_a, busy_a, tx_done_a});
        end
        vectors++;
        if ({tx_b, tx_ready_b, busy_b, tx_done_b} !== 4'b1100) begin
            miscompares++;
            $display("FAIL %s dut_b {tx,ready,busy,done}: got %b expected 1100", name,
                     {tx_b, tx_ready_b, busy_b, tx_done_b});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle_outputs("reset_held");
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_single_byte();
        @(negedge clk);
        tx_data_a  = 8'hA5;
        tx_valid_a = 1'b1;
        check_frame(1'b0, FR_A5, FB_A, CPB_A, 1'b0, "single_a5");
    endtask

    task automatic test_back_to_back();
        int acc0;
        acc0 = acc_a;
        @(negedge clk);
        tx_data_a  = 8'h00;
        tx_valid_a = 1'b1;
        check_frame(1'b0, FR_00, FB_A, CPB_A, 1'b1, "b2b_first_00");
        tx_data_a = 8'hFF;
        check_frame(1'b0, FR_FF, FB_A, CPB_A, 1'b0, "b2b_second_ff");
        repeat (5) @(negedge clk);
        vectors++;
        if (acc_a - acc0 !== 2) begin
            miscompares++;
            $display("FAIL b2b_accept_count: got %0d expected 2", acc_a - acc0);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        tx_data_a  = 8'hA5;
        tx_valid_a = 1'b1;
        check_frame(1'b0, FR_A5, FB_A, CPB_A, 1'b0, "parity_a5");
        @(negedge clk);
        tx_data_a  = 8'h07;
        tx_valid_a = 1'b1;
        check_frame(1'b0, FR_07, FB_A, CPB_A, 1'b0, "parity_07");
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [15:0] fr;
        int done_seen;
        int tx_low;
        fr = FR_3C;
        @(negedge clk);
        tx_data_a  = 8'h3C;
        tx_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (tx_a !== fr[3]) begin
            miscompares++;
            $display("FAIL abort_tx_cycle13: got %b expected %b", tx_a, fr[3]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("abort_next_cycle");
        done_seen = 0;
        tx_low    = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_done_a !== 1'b0) done_seen++;
            if (tx_a !== 1'b1) tx_low++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen);
        end
        vectors++;
        if (tx_low !== 0) begin
            miscompares++;
            $display("FAIL abort_line_idle: got %0d low cycles expected 0", tx_low);
        end
        tx_data_a  = 8'h3C;
        tx_valid_a = 1'b1;
        check_frame(1'b0, FR_3C, FB_A, CPB_A, 1'b0, "resend_3c");
    endtask

    task automatic test_min_rate();
        int acc0;
        acc0 = acc_b;
        @(negedge clk);
        tx_data_b  = 5'h15;
        tx_valid_b = 1'b1;
        check_frame(1'b1, FR_15, FB_B, CPB_B, 1'b0, "min_rate_15");
        vectors++;
        if (acc_b - acc0 !== 1) begin
            miscompares++;
            $display("FAIL min_rate_accept_count: got %0d expected 1", acc_b - acc0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        tx_data_a  = '0;
        tx_valid_a = 1'b0;
        tx_data_b  = '0;
        tx_valid_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        test_reset();
        test_single_byte();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_min_rate();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
